// File: rtl/spi_regfile_if.sv
// Register bus between the SPI register slave (master side) and spi_regfile (slave side).
interface spi_regfile_if #(
  parameter int ADDR_W = 3,
  parameter int REG_W  = 8
);
  logic [ADDR_W-1:0] reg_addr;
  logic [REG_W-1:0]  reg_wdata;
  logic              reg_wdata_dv;
  logic [REG_W-1:0]  reg_rdata;

  modport master (output reg_addr, output reg_wdata, output reg_wdata_dv, input reg_rdata);
  modport slave  (input reg_addr, input reg_wdata, input reg_wdata_dv, output reg_rdata);
endinterface

// File: rtl/spi_regfile.sv
// Byte-wide 8-entry register bank for the TDC: control/config outputs, result snapshot, sticky flags.
// Optional macro SPI_REGFILE_IRQ_EN enables the irq mask (CFG[1:0]) and irq_o.
module spi_regfile #(
  parameter int              ADDR_W = 3,
  parameter int              REG_W  = 8,
  parameter int              RES_W  = 24,
  parameter logic [REG_W-1:0] ID_VAL = 8'hA5
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  spi_regfile_if.slave     bus,
  input  logic [RES_W-1:0] result_i,
  input  logic             result_dv_i,
  input  logic             busy_i,
  output logic             ctrl_en_o,
  output logic             start_o,
  output logic [5:0]       cfg_o,
  output logic             irq_o
);

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_CFG    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_RES0   = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_RES1   = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_RES2   = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_SCR    = ADDR_W'(6);

  // start and clr are action bits: never stored, so they read back as 0
  localparam logic [REG_W-1:0] CTRL_MASK = REG_W'(8'hF9);
`ifdef SPI_REGFILE_IRQ_EN
  localparam logic [REG_W-1:0] CFG_MASK  = REG_W'(8'hFF);
`else
  localparam logic [REG_W-1:0] CFG_MASK  = REG_W'(8'hFC);
`endif

  logic [REG_W-1:0] ctrl_q, ctrl_d;
  logic [REG_W-1:0] cfg_q, cfg_d;
  logic [REG_W-1:0] scratch_q, scratch_d;
  logic [REG_W-1:0] rdata_q, rdata_d;
  logic [23:0]      snap_q, snap_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             start_q, start_d;

  logic             wr, wr_ctrl, wr_cfg, wr_status, wr_scr;
  logic             clr, w1c_valid, w1c_ovf, cap;
  logic             valid_base, ovf_base;
  logic [23:0]      res_ext;
  logic [REG_W-1:0] rd_mux;
  logic [REG_W-1:0] res_byte [3];

  always_comb begin
    res_ext              = '0;
    res_ext[RES_W-1:0]   = result_i;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_res_byte
      assign res_byte[gi] = REG_W'(snap_q[gi*8 +: 8]);
    end
  endgenerate

  always_comb begin
    rd_mux = ID_VAL;
    case (bus.reg_addr)
      A_CTRL:   rd_mux = ctrl_q;
      A_CFG:    rd_mux = cfg_q;
      A_STATUS: rd_mux = REG_W'({busy_i, ovf_q, valid_q});
      A_RES0:   rd_mux = res_byte[0];
      A_RES1:   rd_mux = res_byte[1];
      A_RES2:   rd_mux = res_byte[2];
      A_SCR:    rd_mux = scratch_q;
      default:  rd_mux = ID_VAL;
    endcase
  end

  always_comb begin
    wr        = ena & bus.reg_wdata_dv;
    wr_ctrl   = wr && (bus.reg_addr == A_CTRL);
    wr_cfg    = wr && (bus.reg_addr == A_CFG);
    wr_status = wr && (bus.reg_addr == A_STATUS);
    wr_scr    = wr && (bus.reg_addr == A_SCR);
    clr       = wr_ctrl & bus.reg_wdata[2];
    w1c_valid = wr_status & bus.reg_wdata[0];
    w1c_ovf   = wr_status & bus.reg_wdata[1];
    cap       = ena & result_dv_i;

    // Clears are applied before the capture, so a same-cycle result always lands
    valid_base = valid_q & ~clr & ~w1c_valid;
    ovf_base   = ovf_q & ~clr & ~w1c_ovf;

    ctrl_d    = wr_ctrl ? (bus.reg_wdata & CTRL_MASK) : ctrl_q;
    cfg_d     = wr_cfg ? (bus.reg_wdata & CFG_MASK) : cfg_q;
    scratch_d = wr_scr ? bus.reg_wdata : scratch_q;
    valid_d   = cap | valid_base;
    ovf_d     = ovf_base | (cap & valid_base);

    snap_d = snap_q;
    if (clr)
      snap_d = '0;
    if (cap && !valid_base)
      snap_d = res_ext;

    start_d = wr_ctrl & bus.reg_wdata[1];
    rdata_d = ena ? rd_mux : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      ctrl_q    <= '0;
      cfg_q     <= '0;
      scratch_q <= '0;
      rdata_q   <= '0;
      snap_q    <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      cfg_q     <= cfg_d;
      scratch_q <= scratch_d;
      rdata_q   <= rdata_d;
      snap_q    <= snap_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      start_q   <= start_d;
    end
  end

`ifdef SPI_REGFILE_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = ena ? |({ovf_q, valid_q} & cfg_q[1:0]) : irq_q;
  end

  always_ff @(posedge clk) begin
    if (!rstb)
      irq_q <= 1'b0;
    else
      irq_q <= irq_d;
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  assign bus.reg_rdata = rdata_q;
  assign ctrl_en_o     = ctrl_q[0];
  assign start_o       = start_q;
  assign cfg_o         = cfg_q[7:2];

endmodule

// File: tb/tb_spi_regfile.sv
// Bench for spi_regfile: directed vector table followed by randomized traffic against a reference model.
module tb_spi_regfile;

`ifdef SPI_REGFILE_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstb;
  logic        ena;
  logic [23:0] result_i;
  logic        result_dv_i;
  logic        busy_i;
  logic        ctrl_en_o;
  logic        start_o;
  logic [5:0]  cfg_o;
  logic        irq_o;

  spi_regfile_if #(.ADDR_W(3), .REG_W(8)) bus ();

  spi_regfile #(.ADDR_W(3), .REG_W(8), .RES_W(24), .ID_VAL(8'hA5)) dut (
    .clk         (clk),
    .rstb        (rstb),
    .ena         (ena),
    .bus         (bus),
    .result_i    (result_i),
    .result_dv_i (result_dv_i),
    .busy_i      (busy_i),
    .ctrl_en_o   (ctrl_en_o),
    .start_o     (start_o),
    .cfg_o       (cfg_o),
    .irq_o       (irq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rstb;
    bit         ena;
    logic [2:0] addr;
    logic [7:0] wd;
    bit         dv;
    logic [23:0] res;
    bit         rdv;
    bit         busy;
    logic [7:0] e_rd;
    bit         e_en;
    bit         e_st;
    logic [5:0] e_cfg;
    bit         e_irq;
  } vec_t;

  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Reference model: register contents as the map describes them
  logic [7:0]  m_ctrl, m_cfg, m_scr, m_rd;
  logic [23:0] m_snap;
  bit          m_valid, m_ovf, m_start, m_irq;

  function automatic void r(bit rs, bit en, logic [2:0] a, logic [7:0] wd, bit dv,
                            logic [23:0] res, bit rdv, bit busy,
                            logic [7:0] e_rd, bit e_en, bit e_st, logic [5:0] e_cfg, bit e_irq);
    vec_t v;
    v.rstb = rs; v.ena = en; v.addr = a; v.wd = wd; v.dv = dv;
    v.res = res; v.rdv = rdv; v.busy = busy;
    v.e_rd = e_rd; v.e_en = e_en; v.e_st = e_st; v.e_cfg = e_cfg; v.e_irq = e_irq;
    tbl.push_back(v);
  endfunction

  function automatic logic [7:0] m_read(logic [2:0] a, bit busy);
    case (a)
      3'd0:    return m_ctrl;
      3'd1:    return m_cfg;
      3'd2:    return {5'b0, busy, m_ovf, m_valid};
      3'd3:    return m_snap[7:0];
      3'd4:    return m_snap[15:8];
      3'd5:    return m_snap[23:16];
      3'd6:    return m_scr;
      default: return 8'hA5;
    endcase
  endfunction

  task automatic model_step(input vec_t v);
    logic [7:0] n_rd;
    bit         n_irq, n_st;
    if (!v.rstb) begin
      m_ctrl = 0; m_cfg = 0; m_scr = 0; m_rd = 0; m_snap = 0;
      m_valid = 0; m_ovf = 0; m_start = 0; m_irq = 0;
    end else if (!v.ena) begin
      m_start = 0;
    end else begin
      n_rd  = m_read(v.addr, v.busy);
      n_irq = IRQ_EN && ((m_valid && m_cfg[0]) || (m_ovf && m_cfg[1]));
      n_st  = v.dv && v.addr == 3'd0 && v.wd[1];
      if (v.dv) begin
        case (v.addr)
          3'd0: begin
            m_ctrl = v.wd & 8'hF9;
            if (v.wd[2]) begin m_valid = 0; m_ovf = 0; m_snap = 0; end
          end
          3'd1: m_cfg = IRQ_EN ? v.wd : (v.wd & 8'hFC);
          3'd2: begin
            if (v.wd[0]) m_valid = 0;
            if (v.wd[1]) m_ovf = 0;
          end
          3'd6: m_scr = v.wd;
          default: ;
        endcase
      end
      if (v.rdv) begin
        if (!m_valid) begin m_snap = v.res; m_valid = 1; end
        else m_ovf = 1;
      end
      m_rd = n_rd; m_irq = n_irq; m_start = n_st;
    end
  endtask

  task automatic apply(input vec_t v);
    rstb = v.rstb; ena = v.ena;
    bus.reg_addr = v.addr; bus.reg_wdata = v.wd; bus.reg_wdata_dv = v.dv;
    result_i = v.res; result_dv_i = v.rdv; busy_i = v.busy;
    @(posedge clk);
    #1;
    model_step(v);
  endtask

  task automatic compare(input string name, input int idx, input logic [16:0] exp);
    logic [16:0] act;
    act = {bus.reg_rdata, ctrl_en_o, start_o, cfg_o, irq_o};
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s #%0d {rdata,en,start,cfg,irq}: got %h/%b/%b/%h/%b want %h/%b/%b/%h/%b",
               name, idx, act[16:9], act[8], act[7], act[6:1], act[0],
               exp[16:9], exp[8], exp[7], exp[6:1], exp[0]);
    end else begin
      $display("%s #%0d ok rdata=%h en=%b start=%b cfg=%h irq=%b",
               name, idx, act[16:9], act[8], act[7], act[6:1], act[0]);
    end
  endtask

  initial begin
    logic [7:0] cfd;
    logic [7:0] c03;
    bit         I;
    vec_t       v;
    I   = IRQ_EN;
    cfd = I ? 8'hFD : 8'hFC;
    c03 = I ? 8'h03 : 8'h00;

    // reset, then read every address
    r(0,1,0,8'h00,0,0,0,0, 8'h00,0,0,0,0);
    r(0,1,0,8'h00,0,0,0,0, 8'h00,0,0,0,0);
    for (int a = 0; a < 7; a++) r(1,1,3'(a),8'h00,0,0,0,0, 8'h00,0,0,0,0);
    r(1,1,7,8'h00,0,0,0,0, 8'hA5,0,0,0,0);
    // CTRL / CFG writes
    r(1,1,0,8'h03,1,0,0,0, 8'h00,1,1,6'h00,0);
    r(1,1,0,8'h00,0,0,0,0, 8'h01,1,0,6'h00,0);
    r(1,1,1,8'hFD,1,0,0,0, 8'h00,1,0,6'h3F,0);
    r(1,1,1,8'h00,0,0,0,0, cfd,  1,0,6'h3F,0);
    // capture and overflow
    r(1,1,2,8'h00,0,24'h123456,1,0, 8'h00,1,0,6'h3F,0);
    r(1,1,2,8'h00,0,0,0,0, 8'h01,1,0,6'h3F,I);
    r(1,1,3,8'h00,0,0,0,0, 8'h56,1,0,6'h3F,I);
    r(1,1,4,8'h00,0,0,0,0, 8'h34,1,0,6'h3F,I);
    r(1,1,5,8'h00,0,24'hABCDEF,1,0, 8'h12,1,0,6'h3F,I);
    r(1,1,2,8'h00,0,0,0,0, 8'h03,1,0,6'h3F,I);
    r(1,1,3,8'h00,0,0,0,0, 8'h56,1,0,6'h3F,I);
    // W1C valid, irq drop, mask on ovf
    r(1,1,2,8'h01,1,0,0,0, 8'h03,1,0,6'h3F,I);
    r(1,1,2,8'h00,0,0,0,0, 8'h02,1,0,6'h3F,0);
    r(1,1,2,8'h00,0,0,0,0, 8'h02,1,0,6'h3F,0);
    r(1,1,1,8'h03,1,0,0,0, cfd,  1,0,6'h00,0);
    r(1,1,1,8'h00,0,0,0,0, c03,  1,0,6'h00,I);
    r(1,1,2,8'h02,1,0,0,0, 8'h02,1,0,6'h00,I);
    r(1,1,2,8'h00,0,0,0,0, 8'h00,1,0,6'h00,0);
    // same-cycle W1C valid + capture, clr + capture
    r(1,1,2,8'h00,0,24'h000011,1,0, 8'h00,1,0,6'h00,0);
    r(1,1,2,8'h01,1,24'h000042,1,0, 8'h01,1,0,6'h00,I);
    r(1,1,2,8'h00,0,0,0,0, 8'h01,1,0,6'h00,I);
    r(1,1,3,8'h00,0,0,0,0, 8'h42,1,0,6'h00,I);
    r(1,1,0,8'h04,1,24'h000077,1,0, 8'h01,0,0,6'h00,I);
    r(1,1,2,8'h00,0,0,0,0, 8'h01,0,0,6'h00,I);
    r(1,1,3,8'h00,0,0,0,0, 8'h77,0,0,6'h00,I);
    // RO writes ignored, ena=0 ignored, live busy
    r(1,1,3,8'hFF,1,0,0,0, 8'h77,0,0,6'h00,I);
    r(1,1,7,8'h00,1,0,0,0, 8'hA5,0,0,6'h00,I);
    r(1,1,3,8'h00,0,0,0,0, 8'h77,0,0,6'h00,I);
    r(1,1,7,8'h00,0,0,0,0, 8'hA5,0,0,6'h00,I);
    r(1,0,6,8'h5A,1,0,0,0, 8'hA5,0,0,6'h00,I);
    r(1,1,6,8'h00,0,0,0,0, 8'h00,0,0,6'h00,I);
    r(1,1,2,8'h00,0,0,0,1, 8'h05,0,0,6'h00,I);
    // W1C ovf together with an overflowing capture keeps ovf
    r(1,1,2,8'h00,0,24'h000099,1,0, 8'h01,0,0,6'h00,I);
    r(1,1,2,8'h02,1,24'h000055,1,0, 8'h03,0,0,6'h00,I);
    r(1,1,2,8'h00,0,0,0,0, 8'h03,0,0,6'h00,I);
    r(1,1,3,8'h00,0,0,0,0, 8'h77,0,0,6'h00,I);
    // build state, then reset mid-sequence with a pending write and capture
    r(1,1,6,8'h5A,1,0,0,0, 8'h00,0,0,6'h00,I);
    r(1,1,0,8'h09,1,0,0,0, 8'h00,1,0,6'h00,I);
    r(1,1,6,8'h00,0,0,0,0, 8'h5A,1,0,6'h00,I);
    r(0,1,6,8'hFF,1,24'h000123,1,0, 8'h00,0,0,6'h00,0);
    r(1,1,6,8'h00,0,0,0,0, 8'h00,0,0,6'h00,0);
    r(1,1,0,8'h00,0,0,0,0, 8'h00,0,0,6'h00,0);
    r(1,1,1,8'h00,0,0,0,0, 8'h00,0,0,6'h00,0);
    r(1,1,2,8'h00,0,0,0,0, 8'h00,0,0,6'h00,0);
    r(1,1,3,8'h00,0,0,0,0, 8'h00,0,0,6'h00,0);
    r(1,1,7,8'h00,0,0,0,0, 8'hA5,0,0,6'h00,0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      compare("dir", i, {tbl[i].e_rd, tbl[i].e_en, tbl[i].e_st, tbl[i].e_cfg, tbl[i].e_irq});
    end

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      v = '{default: 0};
      v.rstb = (i < 2) ? 1'b0 : ($urandom_range(0, 99) != 0);
      v.ena  = ($urandom_range(0, 9) != 0);
      v.addr = 3'($urandom_range(0, 7));
      v.wd   = 8'($urandom);
      v.dv   = ($urandom_range(0, 2) == 0);
      v.res  = 24'($urandom);
      v.rdv  = ($urandom_range(0, 3) == 0);
      v.busy = 1'($urandom);
      apply(v);
      compare("rnd", i, {m_rd, m_ctrl[0], m_start, m_cfg[7:2], m_irq});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/spi_regfile.md
Name: spi_regfile

Overview:
Register bank that sits directly downstream of the SPI register slave.
- Consumes the slave's address, write data and write strobe.
- Returns read data for the slave's TX load.
- Exposes control outputs to the TDC core and captures TDC results into byte-readable snapshot registers with sticky status flags.
- Byte-wide, 8 addresses. All state is clocked on clk and qualified by ena.

Parameters:
ADDR_W, 3, register address width (fixed map uses 8 addresses)
REG_W, 8, register data width
RES_W, 24, TDC result width, 1..24; result bits above RES_W-1 read 0
ID_VAL, 8'hA5, constant returned at address 7

Ports:
clk  in  1  system clock
rstb  in  1  reset, synchronous, active-low
ena  in  1  global enable; when 0 all registers hold and pulses are suppressed
reg_addr  in  ADDR_W  register address from SPI slave
reg_wdata  in  REG_W  write data from SPI slave
reg_wdata_dv  in  1  single-cycle write strobe
reg_rdata  out  REG_W  registered read data to SPI slave TX load
result_i  in  RES_W  TDC measurement
result_dv_i  in  1  single-cycle result-valid strobe
busy_i  in  1  TDC busy (live)
ctrl_en_o  out  1  TDC enable
start_o  out  1  one-cycle start pulse
cfg_o  out  6  TDC configuration
irq_o  out  1  interrupt, level, active-high

Behaviour:
Register map:
- 0 CTRL RW
  - bit0 en → ctrl_en_o
  - bit1 start: write-1 pulses start_o, reads 0
  - bit2 clr: write-1 clears result and STATUS[1:0], reads 0
  - bits7:3 RW scratch
- 1 CFG RW
  - bits1:0 irq_mask
  - bits7:2 → cfg_o
- 2 STATUS
  - bit0 valid: sticky, W1C
  - bit1 ovf: sticky, W1C
  - bit2 busy_i: live, RO
  - bits7:3 read 0
- 3/4/5 RES0/RES1/RES2 RO: result snapshot bytes [7:0], [15:8], [23:16]
- 6 SCRATCH RW
- 7 ID RO = ID_VAL

Writes:
- Take effect on the cycle where reg_wdata_dv=1 and ena=1; visible on outputs the next cycle.
- Writes to RO addresses (3, 4, 5, 7) are ignored.

Read path:
- reg_rdata <= mux(reg_addr) every enabled cycle, giving 1-cycle latency.
- The slave loads TX two cycles after updating the address, so this latency is sufficient.

start_o:
- High exactly one cycle after a CTRL write with bit1=1, regardless of bit0.
- Back-to-back writes give back-to-back pulses.

Capture on result_dv_i:
- If valid=0: snapshot <= zero-extended result_i, valid <= 1.
- If valid=1: snapshot is held, ovf <= 1.

Simultaneous events:
- W1C of valid together with result_dv_i: the set wins. Snapshot is captured (treated as valid=0 for capture); ovf is not set.
- W1C of ovf together with an overflowing result_dv_i: ovf stays 1.
- CTRL clr together with result_dv_i: the clear applies first, then the capture, so valid=1 with the new snapshot.

irq_o = |(STATUS[1:0] & irq_mask), registered (1 cycle after the flag change).

Reset (rstb=0 at posedge clk, overrides ena):
- All RW registers, snapshot and flags = 0.
- ctrl_en_o=0, start_o=0, cfg_o=0, irq_o=0, reg_rdata=0.
- Reset mid-transfer discards any pending write and capture.

ena=0: strobes arriving that cycle are ignored (not queued).

Optional Feature:
SPI_REGFILE_IRQ_EN
- Defined: irq_mask and irq_o behave as above.
- Undefined: irq_o tied 0, CFG bits1:0 are not stored and read 0; cfg_o is unaffected.

Test Plan:
1. Reset with rstb=0 for 2 cycles, then read all addresses → 0x00 for addr 0–6, 0xA5 for addr 7; all outputs 0.
2. Write CTRL=0x03 → ctrl_en_o=1 next cycle, start_o high exactly one cycle, CTRL reads 0x01. Write CFG=0xFD → cfg_o=6'h3F, CFG reads 0xFD.
3. result_dv_i with result_i=24'h123456 → RES0/1/2 read 0x56/0x34/0x12, STATUS=0x01. Second dv with 24'hABCDEF → RES unchanged, STATUS=0x03.
4. With CFG=0x01 and valid=1 → irq_o=1. Write STATUS=0x01 → valid=0, irq_o falls one cycle later. With SPI_REGFILE_IRQ_EN undefined → irq_o stays 0 and CFG reads 0x00 after writing 0x03.
5. Same-cycle STATUS W1C 0x01 and result_dv_i=24'h000042 → STATUS=0x01, RES0=0x42. Same-cycle CTRL=0x04 and dv → valid=1 with the new value.
6. Write RES0=0xFF and ID=0x00 → reads unchanged. Assert ena=0 during a write of SCRATCH=0x5A → SCRATCH stays 0x00. Assert rstb=0 mid-sequence → every register returns to reset values.
